// File: rtl/retire_trace_unit_pkg.sv
// Shared types and defaults for the retirement trace unit.
package riscv_trace_pkg;

  localparam int DEPTH_DEFAULT = 8;
  localparam int SEQ_W_DEFAULT = 16;

  // Lifecycle of the trace stream: capture, flush after halt, finished.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Architectural effects of one retired instruction.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        rd_we;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
  } trace_pkt_t;

endpackage

// File: rtl/retire_trace_unit_if.sv
// Trace packet stream between the retire trace unit and its consumer.
interface retire_trace_unit_if #(
  parameter int SEQ_W = riscv_trace_pkg::SEQ_W_DEFAULT
);
  logic             tr_valid;
  logic             tr_ready;
  logic [SEQ_W-1:0] tr_seq;
  logic [31:0]      tr_pc;
  logic [31:0]      tr_instr;
  logic             tr_rd_we;
  logic [4:0]       tr_rd;
  logic [31:0]      tr_rd_data;
  logic             tr_mem_we;
  logic [31:0]      tr_mem_addr;
  logic [31:0]      tr_mem_data;

  // Producer side: the trace unit.
  modport master (
    output tr_valid, tr_seq, tr_pc, tr_instr, tr_rd_we, tr_rd, tr_rd_data,
           tr_mem_we, tr_mem_addr, tr_mem_data,
    input  tr_ready
  );

  // Consumer side: whatever collects the trace.
  modport slave (
    input  tr_valid, tr_seq, tr_pc, tr_instr, tr_rd_we, tr_rd, tr_rd_data,
           tr_mem_we, tr_mem_addr, tr_mem_data,
    output tr_ready
  );
endinterface

// File: rtl/retire_trace_unit_fifo.sv
// Circular trace buffer; the caller guarantees no push when full without a pop.
module trace_fifo
  import riscv_trace_pkg::*;
#(
  parameter int  DEPTH  = DEPTH_DEFAULT,
  parameter type elem_t = trace_pkt_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  elem_t                    din,
  output elem_t                    dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  elem_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Entry storage write.
  // NOTE: the array has no reset; an empty FIFO masks its head, so stale contents never leak out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/retire_trace_unit.sv
// Captures retired instructions into an ordered, sequence-numbered trace stream.
module retire_trace_unit
  import riscv_trace_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int SEQ_W = SEQ_W_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wb_valid,
  input  logic [31:0]                 wb_pc,
  input  logic [31:0]                 wb_instr,
  input  logic                        wb_rd_we,
  input  logic [4:0]                  wb_rd,
  input  logic [31:0]                 wb_rd_data,
  input  logic                        wb_mem_we,
  input  logic [31:0]                 wb_mem_addr,
  input  logic [31:0]                 wb_mem_wdata,
  input  logic                        halt_in,
  output logic                        stall_req,
  retire_trace_unit_if.master         tr,
  output logic                        overflow,
  output logic [7:0]                  drop_cnt,
  output logic                        done
);
  localparam int AW = $clog2(DEPTH);
  // Two entries of slack cover the pipeline's reaction delay to stall_req.
  localparam logic [AW:0] STALL_LEVEL = (AW+1)'(DEPTH - 2);

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    trace_pkt_t       body;
  } entry_t;

  state_t           state;
  state_t           state_next;
  logic             capture_en;
  logic             stream_en;
  logic             push;
  logic             pop;
  logic             drop;
  logic             full;
  logic             empty;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic [SEQ_W-1:0] seq;
  entry_t           din;
  entry_t           dout;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_next;
  end

  // Halt starts the flush; the flush ends once the buffer is empty after an edge.
  always_comb begin
    state_next = state;
    unique case (state)
      RUN:     if (halt_in) state_next = (count_next == '0) ? DONE : DRAIN;
      DRAIN:   if (count_next == '0) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = RUN;
    endcase
  end

  // Per-state enables for capture, streaming and completion.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    capture_en = 1'b0;
    stream_en  = 1'b0;
    done       = 1'b0;
    unique case (state)
      RUN: begin
        capture_en = 1'b1;
        stream_en  = 1'b1;
      end
      DRAIN:   stream_en = 1'b1;
      DONE:    done      = 1'b1;
      default: ;
    endcase
  end

  // A full buffer still accepts a retirement if the head leaves on the same edge.
  assign pop        = tr.tr_valid && tr.tr_ready;
  assign push       = capture_en && wb_valid && (!full || pop);
  assign drop       = capture_en && wb_valid && !push;
  assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);

  assign din = '{
    seq:  seq,
    body: '{
      pc:       wb_pc,
      instr:    wb_instr,
      rd_we:    wb_rd_we && (wb_rd != 5'd0),
      rd:       wb_rd,
      rd_data:  wb_rd_data,
      mem_we:   wb_mem_we,
      mem_addr: wb_mem_addr,
      mem_data: wb_mem_wdata
    }
  };

  trace_fifo #(
    .DEPTH  (DEPTH),
    .elem_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Sequence numbering, drop accounting and registered backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seq       <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
      stall_req <= 1'b0;
    end else begin
      if (push) seq <= seq + SEQ_W'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
      stall_req <= (state_next != DONE) && (count_next >= STALL_LEVEL);
    end
  end

  assign tr.tr_valid    = stream_en && !empty;
  assign tr.tr_seq      = dout.seq;
  assign tr.tr_pc       = dout.body.pc;
  assign tr.tr_instr    = dout.body.instr;
  assign tr.tr_rd_we    = dout.body.rd_we;
  assign tr.tr_rd       = dout.body.rd;
  assign tr.tr_rd_data  = dout.body.rd_data;
  assign tr.tr_mem_we   = dout.body.mem_we;
  assign tr.tr_mem_addr = dout.body.mem_addr;
  assign tr.tr_mem_data = dout.body.mem_data;

endmodule
